// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// -----------------
// AHB-Lite slave to APB initiator bridge. Each accepted AHB transfer is
// decoded to one of six APB slots (UART0, timer, watchdog, dual timer,
// UART1, SPI). The bridge runs one APB SETUP/ACCESS handshake for it and
// returns the merged APB response as HREADYOUT/HRDATA/HRESP. Addresses in
// slots 6..15 receive a two-cycle AHB ERROR response and make no APB access.
//
// Handshake semantics:
//   AHB: a transfer is taken on a rising HCLK edge when
//        HSEL & HTRANS[1] & HREADY & HREADYOUT. HREADYOUT is high only in IDLE
//        and ERR2, so at most one transfer is ever in flight.
//   APB: the selected PSELn is high for SETUP and ACCESS, and PENABLE is high
//        only in ACCESS. The access completes on the edge where PREADY=1 in
//        ACCESS. PSLVERR is sampled on that edge.
//
// Ports:
//   HCLK, HRESET          clock and synchronous active-high reset
//   HSEL..HREADY          AHB-Lite slave-side inputs
//   HREADYOUT/HRDATA/HRESP AHB-Lite response
//   PADDR..PPROT          APB request (registered)
//   PREADY/PRDATA/PSLVERR merged APB response
//   dbg_state             current FSM state (observation only)
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL0,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PSEL3,
  output logic                  PSEL4,
  output logic                  PSEL5,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  output logic [2:0]            PPROT,
  input  logic                  PREADY,
  input  logic [31:0]           PRDATA,
  input  logic                  PSLVERR,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLAT   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  state_t      state, next_state;
  logic        accept;
  logic [3:0]  hslot;
  logic [3:0]  slot_q;
  logic [3:0]  sel_slot;
  logic [5:0]  psel_q, psel_d;
  logic        penable_d;
  logic [3:0]  strb_d;

  // Address bits above the APB window, HTRANS[0] (SEQ vs NONSEQ) and the
  // cacheable/bufferable HPROT bits have no meaning on this APB segment.
  logic unused_inputs;
  assign unused_inputs = ^{HADDR[31:ADDR_WIDTH], HTRANS[0], HPROT[3:2]};

  assign hslot     = HADDR[ADDR_WIDTH-1 -: 4];
  assign HREADYOUT = (state == ST_IDLE) || (state == ST_ERR2);
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
  assign accept    = HSEL & HTRANS[1] & HREADY & HREADYOUT;
  assign dbg_state = state;

  assign {PSEL5, PSEL4, PSEL3, PSEL2, PSEL1, PSEL0} = psel_q;

  // Write strobes from size and low address bits; reads never strobe.
  always_comb begin
    strb_d = 4'b0000;
    if (HWRITE) begin
      case (HSIZE)
        3'd0:    strb_d = 4'b0001 << HADDR[1:0];
        3'd1:    strb_d = HADDR[1] ? 4'b1100 : 4'b0011;
        default: strb_d = 4'b1111;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_ERR2: begin
        next_state = ST_IDLE;
        if (accept) begin
          if (hslot > 4'd5)  next_state = ST_ERR1;
          else if (HWRITE)   next_state = ST_WLAT;
          else               next_state = ST_SETUP;
        end
      end
      ST_WLAT:   next_state = ST_SETUP;
      ST_SETUP:  next_state = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) next_state = PSLVERR ? ST_ERR1 : ST_IDLE;
      end
      ST_ERR1:   next_state = ST_ERR2;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Selects are registered from the next state. A read goes from IDLE
  // straight to SETUP, so the slot must come from HADDR on the accept edge,
  // not from slot_q, which only loads on that same edge.
  always_comb begin
    psel_d    = 6'b000000;
    sel_slot  = accept ? hslot : slot_q;
    penable_d = (next_state == ST_ACCESS);
    if ((next_state == ST_SETUP) || (next_state == ST_ACCESS))
      psel_d = 6'b000001 << sel_slot;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      psel_q  <= 6'b000000;
      PENABLE <= 1'b0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PSTRB   <= 4'b0000;
      PPROT   <= 3'b000;
      slot_q  <= 4'd0;
      PWDATA  <= 32'd0;
      HRDATA  <= 32'd0;
    end else begin
      state   <= next_state;
      psel_q  <= psel_d;
      PENABLE <= penable_d;
      if (accept) begin
        PADDR  <= HADDR[ADDR_WIDTH-1:0];
        PWRITE <= HWRITE;
        PSTRB  <= strb_d;
        PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
        slot_q <= hslot;
      end
      // HWDATA belongs to the AHB data phase, which is the WLAT cycle.
      if (state == ST_WLAT)
        PWDATA <= HWDATA;
      // Read data is loaded on completion whether or not PSLVERR is set.
      if ((state == ST_ACCESS) && PREADY && !PWRITE)
        HRDATA <= PRDATA;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  localparam logic [2:0] S_IDLE = 3'd0, S_WLAT = 3'd1, S_ACCESS = 3'd3, S_ERR1 = 3'd4;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = 32'd0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [3:0]  HPROT = 4'd0;
  logic [31:0] HWDATA = 32'd0;
  logic        HREADY = 1'b1;
  logic        HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic [15:0] PADDR;
  logic        PSEL0, PSEL1, PSEL2, PSEL3, PSEL4, PSEL5;
  logic        PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY = 1'b1;
  logic [31:0] PRDATA = 32'd0;
  logic        PSLVERR = 1'b0;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad = 0;

  // {HREADYOUT, HRESP, PENABLE, PSEL5..PSEL0}
  logic [8:0] ctl;
  assign ctl = {HREADYOUT, HRESP, PENABLE, PSEL5, PSEL4, PSEL3, PSEL2, PSEL1, PSEL0};

  apb_master_bridge #(.ADDR_WIDTH(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .PADDR(PADDR),
    .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3), .PSEL4(PSEL4), .PSEL5(PSEL5),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // clock / global time limit
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic w, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b1; HADDR = a; HWRITE = w; HSIZE = sz;
  endtask

  task automatic idle_bus;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic test_reset;
    HRESET = 1'b1;
    tick; tick;
    total++; if (ctl !== 9'b1_0_0_000000) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 9'b1_0_0_000000); end
    total++; if ({PADDR, PWDATA, HRDATA} !== 80'd0) begin bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", PADDR, PWDATA, HRDATA); end
    total++; if ({PWRITE, PSTRB, PPROT} !== 8'd0) begin bad++; $display("FAIL reset_attr got=%b exp=0", {PWRITE, PSTRB, PPROT}); end
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    HRESET = 1'b0;
    tick;
    total++; if (ctl !== 9'b1_0_0_000000) begin bad++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, 9'b1_0_0_000000); end
  endtask

  task automatic test_word_write;
    PREADY = 1'b1; HPROT = 4'b0011;
    present(32'h0000_1008, 1'b1, 3'd2);
    tick;                               // WLAT
    idle_bus; HWDATA = 32'hDEAD_BEEF;
    total++; if (ctl !== 9'b0_0_0_000000) begin bad++; $display("FAIL ww_wlat_ctl got=%b exp=%b", ctl, 9'b0_0_0_000000); end
    total++; if (dbg_state !== S_WLAT) begin bad++; $display("FAIL ww_wlat_state got=%0d exp=%0d", dbg_state, S_WLAT); end
    tick;                               // SETUP
    HWDATA = 32'h0;
    total++; if (ctl !== 9'b0_0_0_000010) begin bad++; $display("FAIL ww_setup_ctl got=%b exp=%b", ctl, 9'b0_0_0_000010); end
    total++; if (PADDR !== 16'h1008) begin bad++; $display("FAIL ww_paddr got=%h exp=1008", PADDR); end
    total++; if (PWDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ww_pwdata got=%h exp=deadbeef", PWDATA); end
    total++; if ({PWRITE, PSTRB, PPROT} !== 8'b1_1111_001) begin bad++; $display("FAIL ww_attr got=%b exp=%b", {PWRITE, PSTRB, PPROT}, 8'b1_1111_001); end
    tick;                               // ACCESS
    total++; if (ctl !== 9'b0_0_1_000010) begin bad++; $display("FAIL ww_access_ctl got=%b exp=%b", ctl, 9'b0_0_1_000010); end
    total++; if (PWDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ww_pwdata_hold got=%h exp=deadbeef", PWDATA); end
    tick;                               // completion
    total++; if (ctl !== 9'b1_0_0_000000) begin bad++; $display("FAIL ww_done_ctl got=%b exp=%b", ctl, 9'b1_0_0_000000); end
  endtask

  task automatic test_read_wait;
    int waits;
    PREADY = 1'b0; HPROT = 4'b0000;
    present(32'h0000_5004, 1'b0, 3'd2);
    tick;                               // SETUP
    idle_bus;
    total++; if (ctl !== 9'b0_0_0_100000) begin bad++; $display("FAIL rd_setup_ctl got=%b exp=%b", ctl, 9'b0_0_0_100000); end
    total++; if ({PADDR, PWRITE, PSTRB, PPROT} !== {16'h5004, 1'b0, 4'b0000, 3'b100}) begin bad++; $display("FAIL rd_attr got=%h/%b/%b/%b exp=5004/0/0000/100", PADDR, PWRITE, PSTRB, PPROT); end
    waits = 1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (HREADYOUT) break;
      waits++;
      total++; if (ctl !== 9'b0_0_1_100000) begin bad++; $display("FAIL rd_access_ctl got=%b exp=%b", ctl, 9'b0_0_1_100000); end
      if (waits == 4) begin PREADY = 1'b1; PRDATA = 32'h1234_5678; end
    end
    PRDATA = 32'hFFFF_0000;
    total++; if (waits !== 4) begin bad++; $display("FAIL rd_wait_states got=%0d exp=4", waits); end
    total++; if (ctl !== 9'b1_0_0_000000) begin bad++; $display("FAIL rd_done_ctl got=%b exp=%b", ctl, 9'b1_0_0_000000); end
    total++; if (HRDATA !== 32'h1234_5678) begin bad++; $display("FAIL rd_hrdata got=%h exp=12345678", HRDATA); end
  endtask

  task automatic test_slverr;
    PREADY = 1'b1; PSLVERR = 1'b0;
    present(32'h0000_2003, 1'b1, 3'd0);
    tick;                               // WLAT
    idle_bus; HWDATA = 32'h0000_00AB;
    tick;                               // SETUP
    total++; if (ctl !== 9'b0_0_0_000100) begin bad++; $display("FAIL se_setup_ctl got=%b exp=%b", ctl, 9'b0_0_0_000100); end
    total++; if ({PSTRB, PWDATA} !== {4'b1000, 32'h0000_00AB}) begin bad++; $display("FAIL se_strb_data got=%b/%h exp=1000/000000ab", PSTRB, PWDATA); end
    PSLVERR = 1'b1;
    tick;                               // ACCESS, completes with error
    total++; if (ctl !== 9'b0_0_1_000100) begin bad++; $display("FAIL se_access_ctl got=%b exp=%b", ctl, 9'b0_0_1_000100); end
    tick;                               // ERR1
    PSLVERR = 1'b0;
    total++; if (ctl !== 9'b0_1_0_000000) begin bad++; $display("FAIL se_err1_ctl got=%b exp=%b", ctl, 9'b0_1_0_000000); end
    tick;                               // ERR2
    total++; if (ctl !== 9'b1_1_0_000000) begin bad++; $display("FAIL se_err2_ctl got=%b exp=%b", ctl, 9'b1_1_0_000000); end
    tick;                               // IDLE
    total++; if (ctl !== 9'b1_0_0_000000) begin bad++; $display("FAIL se_idle_ctl got=%b exp=%b", ctl, 9'b1_0_0_000000); end
    total++; if (HRDATA !== 32'h1234_5678) begin bad++; $display("FAIL se_hrdata_hold got=%h exp=12345678", HRDATA); end
  endtask

  task automatic test_unmapped;
    present(32'h0000_7000, 1'b0, 3'd2);
    tick;                               // ERR1
    idle_bus;
    total++; if (ctl !== 9'b0_1_0_000000) begin bad++; $display("FAIL um7_err1_ctl got=%b exp=%b", ctl, 9'b0_1_0_000000); end
    total++; if (dbg_state !== S_ERR1) begin bad++; $display("FAIL um7_err1_state got=%0d exp=%0d", dbg_state, S_ERR1); end
    tick;                               // ERR2: next transfer taken here
    total++; if (ctl !== 9'b1_1_0_000000) begin bad++; $display("FAIL um7_err2_ctl got=%b exp=%b", ctl, 9'b1_1_0_000000); end
    present(32'h0000_F000, 1'b1, 3'd2);
    tick;                               // ERR1 directly, no WLAT
    idle_bus;
    total++; if (dbg_state !== S_ERR1) begin bad++; $display("FAIL umf_err1_state got=%0d exp=%0d", dbg_state, S_ERR1); end
    total++; if (ctl !== 9'b0_1_0_000000) begin bad++; $display("FAIL umf_err1_ctl got=%b exp=%b", ctl, 9'b0_1_0_000000); end
    tick;                               // ERR2
    total++; if (ctl !== 9'b1_1_0_000000) begin bad++; $display("FAIL umf_err2_ctl got=%b exp=%b", ctl, 9'b1_1_0_000000); end
    tick;                               // IDLE
    total++; if (ctl !== 9'b1_0_0_000000) begin bad++; $display("FAIL umf_idle_ctl got=%b exp=%b", ctl, 9'b1_0_0_000000); end
    total++; if (PWDATA !== 32'h0000_00AB) begin bad++; $display("FAIL umf_pwdata_hold got=%h exp=000000ab", PWDATA); end
  endtask

  task automatic test_ignored;
    logic [3:0] vec [3];
    // {HSEL, HTRANS, HREADY}
    vec[0] = 4'b1_01_1;
    vec[1] = 4'b0_10_1;
    vec[2] = 4'b1_10_0;
    HADDR = 32'h0000_1000; HWRITE = 1'b1; HSIZE = 3'd2;
    for (int i = 0; i < 3; i++) begin
      {HSEL, HTRANS, HREADY} = vec[i];
      tick;
      total++; if ({dbg_state, ctl} !== {S_IDLE, 9'b1_0_0_000000}) begin bad++; $display("FAIL ign%0d got=%0d/%b exp=%0d/%b", i, dbg_state, ctl, S_IDLE, 9'b1_0_0_000000); end
    end
    HREADY = 1'b1;
    idle_bus;
  endtask

  task automatic test_back_to_back;
    PREADY = 1'b1; PRDATA = 32'hA5A5_5A5A; HPROT = 4'b0000;
    present(32'h0000_3000, 1'b0, 3'd2);
    tick;                               // SETUP
    idle_bus;
    total++; if (ctl !== 9'b0_0_0_001000) begin bad++; $display("FAIL bb_rsetup_ctl got=%b exp=%b", ctl, 9'b0_0_0_001000); end
    tick;                               // ACCESS
    total++; if (ctl !== 9'b0_0_1_001000) begin bad++; $display("FAIL bb_raccess_ctl got=%b exp=%b", ctl, 9'b0_0_1_001000); end
    tick;                               // completion; present the write now
    total++; if (ctl !== 9'b1_0_0_000000) begin bad++; $display("FAIL bb_rdone_ctl got=%b exp=%b", ctl, 9'b1_0_0_000000); end
    total++; if (HRDATA !== 32'hA5A5_5A5A) begin bad++; $display("FAIL bb_hrdata got=%h exp=a5a55a5a", HRDATA); end
    HPROT = 4'b0010;
    present(32'h0000_0010, 1'b1, 3'd1);
    tick;                               // WLAT
    idle_bus; HWDATA = 32'hCAFE_F00D;
    total++; if (dbg_state !== S_WLAT) begin bad++; $display("FAIL bb_wlat_state got=%0d exp=%0d", dbg_state, S_WLAT); end
    tick;                               // SETUP
    PREADY = 1'b0;
    total++; if (ctl !== 9'b0_0_0_000001) begin bad++; $display("FAIL bb_wsetup_ctl got=%b exp=%b", ctl, 9'b0_0_0_000001); end
    total++; if ({PADDR, PWRITE, PSTRB, PPROT} !== {16'h0010, 1'b1, 4'b0011, 3'b101}) begin bad++; $display("FAIL bb_wattr got=%h/%b/%b/%b exp=0010/1/0011/101", PADDR, PWRITE, PSTRB, PPROT); end
    total++; if (PWDATA !== 32'hCAFE_F00D) begin bad++; $display("FAIL bb_pwdata got=%h exp=cafef00d", PWDATA); end
    tick;                               // ACCESS, stalled
    total++; if (ctl !== 9'b0_0_1_000001) begin bad++; $display("FAIL bb_waccess_ctl got=%b exp=%b", ctl, 9'b0_0_1_000001); end
    tick;                               // still stalled; reset now
    total++; if (dbg_state !== S_ACCESS) begin bad++; $display("FAIL bb_stall_state got=%0d exp=%0d", dbg_state, S_ACCESS); end
    HRESET = 1'b1;
    tick;
    total++; if ({dbg_state, ctl} !== {S_IDLE, 9'b1_0_0_000000}) begin bad++; $display("FAIL rst_mid_ctl got=%0d/%b exp=%0d/%b", dbg_state, ctl, S_IDLE, 9'b1_0_0_000000); end
    total++; if ({PADDR, PWDATA, HRDATA} !== 80'd0) begin bad++; $display("FAIL rst_mid_data got=%h/%h/%h exp=0", PADDR, PWDATA, HRDATA); end
    HRESET = 1'b0; PREADY = 1'b1;
    tick;
    total++; if ({dbg_state, ctl} !== {S_IDLE, 9'b1_0_0_000000}) begin bad++; $display("FAIL rst_after_ctl got=%0d/%b exp=%0d/%b", dbg_state, ctl, S_IDLE, 9'b1_0_0_000000); end
  endtask

  initial begin
    test_reset;
    test_word_write;
    test_read_wait;
    test_slverr;
    test_unmapped;
    test_ignored;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

AHB-Lite to APB bridge: the initiator end of the APB segment. It accepts single AHB-Lite transfers, decodes the address to one of six APB peripheral selects, and sequences the APB SETUP/ACCESS handshake. It also converts the merged PREADY/PRDATA/PSLVERR return from the APB response mux into HREADYOUT/HRDATA/HRESP. It sits between the AHB interconnect slave port and the six-slot APB subsystem: UART0, timer, watchdog, dual timer, UART1 and SPI.

## Interface
- ADDR_WIDTH, 16: PADDR width. Slot decode uses HADDR[ADDR_WIDTH-1:ADDR_WIDTH-4].
- HCLK  in  1  clock for the bridge and the APB segment
- HRESET  in  1  reset; synchronous, active-high
- HSEL  in  1  bridge selected
- HADDR  in  32  AHB address
- HTRANS  in  2  transfer type; HTRANS[1]=1 is a valid transfer
- HWRITE  in  1  1=write
- HSIZE  in  3  0=byte, 1=half, 2=word
- HPROT  in  4  protection
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus ready (address-phase qualifier)
- HREADYOUT  out  1  bridge ready
- HRDATA  out  32  read data
- HRESP  out  1  1=ERROR
- PADDR  out  ADDR_WIDTH  APB address, equal to HADDR[ADDR_WIDTH-1:0]
- PSEL0..PSEL5  out  1 each  one-hot peripheral selects
- PENABLE  out  1  ACCESS phase indicator
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSTRB  out  4  byte strobes
- PPROT  out  3  {~HPROT[0], 1'b0, HPROT[1]}
- PREADY  in  1  merged ready from the response mux
- PRDATA  in  32  merged read data
- PSLVERR  in  1  merged slave error

## Operation
- Transfer accept: HSEL & HTRANS[1] & HREADY on a rising edge while HREADYOUT=1. The bridge is in IDLE or ERR2 when this holds.
- On accept, register PADDR, PWRITE, PPROT, PSTRB and the slot number.
- Slot decode: slot = HADDR[ADDR_WIDTH-1:ADDR_WIDTH-4].
  - Slots 0..5 map to PSEL0..5.
  - Slots 6..15 are unmapped: the bridge makes no APB access and goes directly to ERR1.
- PSTRB (writes only; reads drive 4'b0000):
  - byte: 1<<HADDR[1:0]
  - half: HADDR[1] ? 4'b1100 : 4'b0011
  - word, or any HSIZE>=2: 4'b1111
- State machine (encoding free): IDLE, WLAT, SETUP, ACCESS, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. On accept: mapped write goes to WLAT, mapped read goes to SETUP, unmapped goes to ERR1.
  - WLAT: HREADYOUT=0. HWDATA is captured into PWDATA at the end of the cycle, then SETUP.
  - SETUP: selected PSELn=1, PENABLE=0, HREADYOUT=0. Always goes to ACCESS.
  - ACCESS: PSELn=1, PENABLE=1, HREADYOUT=0, with all other APB outputs held stable.
    - PREADY=0: stay in ACCESS (unbounded wait).
    - PREADY=1, PSLVERR=0: go to IDLE. On a read, HRDATA is loaded from PRDATA.
    - PREADY=1, PSLVERR=1: go to ERR1. HRDATA is loaded on reads.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL/PENABLE=0. Goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A transfer accepted here follows the IDLE rules; otherwise go to IDLE.
- PSELn and PENABLE are 0 in every state except SETUP and ACCESS. At most one PSELn is high at any time.
- HRDATA holds its last loaded value until the next completed read.
- PWDATA holds its value until the next write is captured.

## Timing
- All outputs are registered except HREADYOUT and HRESP, which are decoded from state only.
- Reset values: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PADDR=0, PSEL0..5=0, PENABLE=0, PWRITE=0, PWDATA=0, PSTRB=0, PPROT=0.
- HRESET is synchronous and overrides everything. If asserted mid-transfer (including in ACCESS with PREADY=0), the next edge forces all reset values. The APB access is abandoned and no completion is signalled.
- Read with zero-wait APB: accept at edge 0, SETUP in cycle 1, ACCESS in cycle 2. HREADYOUT=1 with valid HRDATA in cycle 3, giving 2 wait states. Each PREADY=0 cycle adds one wait state.
- Write with zero-wait APB: WLAT in cycle 1, SETUP in cycle 2, ACCESS in cycle 3, HREADYOUT=1 in cycle 4 (3 wait states).
- Error response: HRESP=1 for exactly 2 cycles, with HREADYOUT 0 then 1.
- Unmapped access: ERR1 in cycle 1, ERR2 in cycle 2.
- Back-to-back transfers: a transfer presented in the completion cycle (IDLE or ERR2 with HREADYOUT=1) is accepted with no idle gap.
- Transfers with HTRANS[1]=0, HSEL=0 or HREADY=0 are ignored and produce no state change.

## Test plan
- Reset: hold HRESET 2 cycles and release -> all outputs at their reset values, HREADYOUT=1.
- Word write, HADDR=0x0000_1008, HWDATA=0xDEADBEEF, PREADY=1 -> PSEL1 high for 2 cycles, PENABLE only in the 2nd, PADDR=0x1008, PWDATA=0xDEADBEEF, PSTRB=4'b1111, HREADYOUT low for 3 cycles.
- Read of HADDR=0x5004 with PREADY low for 2 ACCESS cycles, then PRDATA=0x12345678 -> PSEL5 held stable, 4 wait states, HRDATA=0x12345678, HRESP=0.
- Byte write to 0x2003 with PSLVERR=1 at PREADY -> PSTRB=4'b1000, then HRESP=1 for 2 cycles with HREADYOUT 0 then 1.
- Access to 0x7000 -> no PSEL asserted, 2-cycle ERROR response. Access to 0xF000 -> same behaviour.
- Read at 0x3000 immediately followed by a write at 0x0010 in the completion cycle -> second transfer accepted with no gap, PSEL3 then PSEL0. Then assert HRESET while in ACCESS with PREADY=0 -> next cycle PSEL and PENABLE are 0 and the state is IDLE.
